// File: rtl/register_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages that collapse bubbles and
// back-propagate stalls, with synchronous flush and a registered occupancy count.
module register_pipe #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] load;
    logic [N-1:0]     data_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             xfer_in;
    logic             xfer_out;

    // A valid stage advances when the consumer takes the tail or any later stage is empty.
    always_comb begin : adv_chain
        logic bubble_above;
        adv          = '0;
        bubble_above = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            adv[i]       = valid_q[i] & (out_ready | bubble_above);
            bubble_above = bubble_above | ~valid_q[i];
        end
    end

    assign xfer_out = adv[DEPTH-1];
    assign in_ready = ~flush & (~valid_q[0] | adv[0]);
    assign xfer_in  = in_valid & in_ready;

    // Next-state valids, data-load enables and occupancy.
    always_comb begin
        valid_d    = valid_q;
        load       = '0;
        load[0]    = xfer_in;
        valid_d[0] = xfer_in | (valid_q[0] & ~adv[0]);
        for (int i = 1; i < int'(DEPTH); i++) begin
            load[i]    = adv[i-1];
            valid_d[i] = adv[i-1] | (valid_q[i] & ~adv[i]);
        end
        count_d = count_q + CW'(xfer_in) - CW'(xfer_out);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Data registers only load on an accepted move, so stalled words hold steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else if (!flush) begin
            if (load[0]) begin
                data_q[0] <= in;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (load[i]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out       = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: directed scenarios then random traffic, compared
// against a queue model where each word tracks how far it has travelled.
module tb_register_pipe;
    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  din;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  dout;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words in FIFO order plus their stage position (head is the oldest).
    logic [N-1:0] mq_data [$];
    int           mq_pos  [$];
    logic         out_zero;

    register_pipe #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The head always moves up until the last stage; every other word can move up to
    // one slot behind wherever its predecessor ends up.
    task automatic model_edge(input logic rst, input logic fl, input logic iv,
                              input logic [N-1:0] d, input logic ordy, input logic acc_ok);
        int limit;
        int np;
        if (rst) begin
            mq_data.delete();
            mq_pos.delete();
            out_zero = 1'b1;
        end else if (fl) begin
            mq_data.delete();
            mq_pos.delete();
        end else begin
            if (mq_pos.size() > 0) begin
                if (mq_pos[0] == DEPTH - 1 && ordy) begin
                    void'(mq_data.pop_front());
                    void'(mq_pos.pop_front());
                end
            end
            limit = DEPTH - 1;
            for (int k = 0; k < mq_pos.size(); k++) begin
                np = mq_pos[k] + 1;
                if (np > limit) np = limit;
                mq_pos[k] = np;
                limit = np - 1;
                if (np == DEPTH - 1) out_zero = 1'b0;
            end
            if (iv && acc_ok) begin
                mq_data.push_back(d);
                mq_pos.push_back(0);
                if (DEPTH == 1) out_zero = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance both.
    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [N-1:0] d, input logic ordy);
        logic exp_rdy;
        logic exp_ov;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        #1;
        exp_rdy = !fl && ((mq_data.size() < DEPTH) || ordy);
        exp_ov  = 1'b0;
        if (mq_pos.size() > 0) exp_ov = (mq_pos[0] == DEPTH - 1);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("count", 32'(count), 32'(mq_data.size()));
        if (exp_ov) check("out_data", 32'(dout), 32'(mq_data[0]));
        else if (out_zero) check("out_after_reset", 32'(dout), 32'(0));
        model_edge(rst, fl, iv, d, ordy, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input logic ordy);
        for (int c = 0; c < cycles; c++) step(1'b0, 1'b0, 1'b0, 8'h00, ordy);
    endtask

    initial begin
        logic [N-1:0] bp_words [5];
        bp_words = '{8'hC5, 8'h11, 8'h22, 8'h33, 8'h44};
        out_zero  = 1'b1;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        din       = 8'hAA;
        out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with a word offered; then single-word latency.
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
        idle(5, 1'b1);

        // Back-to-back stream.
        for (int v = 1; v <= 8; v++) step(1'b0, 1'b0, 1'b1, 8'(v), 1'b1);
        idle(5, 1'b1);

        // Backpressure: fill, stall the fifth word, then release.
        for (int w = 0; w < 4; w++) step(1'b0, 1'b0, 1'b1, bp_words[w], 1'b0);
        step(1'b0, 1'b0, 1'b1, bp_words[4], 1'b0);
        step(1'b0, 1'b0, 1'b1, bp_words[4], 1'b1);
        idle(7, 1'b1);

        // Full pipe with simultaneous in/out transfer.
        for (int w = 0; w < 4; w++) step(1'b0, 1'b0, 1'b1, 8'(8'hA0 + w), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hB0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(7, 1'b1);

        // Flush with three words inside and an input offered.
        for (int w = 0; w < 3; w++) step(1'b0, 1'b0, 1'b1, 8'(8'h50 + w), 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
        idle(2, 1'b1);

        // Same with reset, then a normal push.
        for (int w = 0; w < 3; w++) step(1'b0, 1'b0, 1'b1, 8'(8'h60 + w), 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h78, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h9D, 1'b1);
        idle(5, 1'b1);

        // Random traffic with phases of heavy and light backpressure.
        for (int c = 0; c < 3000; c++) begin
            logic r_rst;
            logic r_fl;
            logic r_iv;
            logic r_ordy;
            r_rst  = ($urandom_range(0, 99) == 0);
            r_fl   = ($urandom_range(0, 47) == 0);
            r_iv   = ($urandom_range(0, 3) != 0);
            if ((c / 64) % 2 == 0) r_ordy = ($urandom_range(0, 9) < 8);
            else                   r_ordy = ($urandom_range(0, 9) < 3);
            step(r_rst, r_fl, r_iv, 8'($urandom), r_ordy);
        end
        idle(8, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
